// File: rtl/io_serdes_pkg.sv
// Shared definitions for the IO_SERDES link bring-up controller: register map,
// error codes and the state encodings used by the controller and its AXI-Lite engine.
package io_serdes_pkg;

  localparam int unsigned SERDES_CTRL_OFFSET = 0;
  localparam int unsigned RXEN_BIT           = 0;
  localparam int unsigned TXEN_BIT           = 1;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_WR_TMO   = 2'd1;
  localparam logic [1:0] ERR_RD_TMO   = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_RX  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WR_TX  = 3'd3,
    ST_RD_REQ = 3'd4,
    ST_RD_DAT = 3'd5,
    ST_UP     = 3'd6,
    ST_ERR    = 3'd7
  } link_state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_WR   = 2'd1,
    PH_AR   = 2'd2,
    PH_R    = 2'd3
  } lite_phase_e;

endpackage

// File: rtl/io_serdes_lite_master.sv
// Single-beat AXI-Lite write/read engine for the serdes config port, with a
// per-phase handshake timeout. done/timeout/ar_acc are combinational strobes.
module io_serdes_lite_master
  import io_serdes_pkg::*;
#(
  parameter int pADDR_WIDTH = 10,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 64
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     req_i,
  input  logic                     wr_i,
  input  logic [pDATA_WIDTH-1:0]   wdata_i,
  output logic                     done_o,
  output logic                     ar_acc_o,
  output logic                     timeout_o,
  output logic [pDATA_WIDTH-1:0]   rdata_o,
  output logic                     m_awvalid,
  output logic [pADDR_WIDTH-1:0]   m_awaddr,
  input  logic                     m_awready,
  output logic                     m_wvalid,
  output logic [pDATA_WIDTH-1:0]   m_wdata,
  output logic [pDATA_WIDTH/8-1:0] m_wstrb,
  input  logic                     m_wready,
  output logic                     m_arvalid,
  output logic [pADDR_WIDTH-1:0]   m_araddr,
  input  logic                     m_arready,
  input  logic                     m_rvalid,
  input  logic [pDATA_WIDTH-1:0]   m_rdata,
  output logic                     m_rready
);

  localparam int TW = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;

  lite_phase_e             phase_q, phase_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    wr_vld_q, wr_vld_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [pDATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                    tmo_last;

  assign tmo_last = (tmo_q == TW'(pTIMEOUT - 1));

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      phase_q   <= PH_IDLE;
      tmo_q     <= '0;
      wr_vld_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      phase_q   <= phase_d;
      tmo_q     <= tmo_d;
      wr_vld_q  <= wr_vld_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wdata_q   <= wdata_d;
    end
  end

  // A completing handshake is checked before the timeout so that it wins a tie.
  always_comb begin
    phase_d   = phase_q;
    tmo_d     = tmo_q;
    wr_vld_d  = wr_vld_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    wdata_d   = wdata_q;
    done_o    = 1'b0;
    ar_acc_o  = 1'b0;
    timeout_o = 1'b0;
    unique case (phase_q)
      PH_IDLE: begin
        tmo_d = '0;
        if (req_i) begin
          if (wr_i) begin
            wdata_d  = wdata_i;
            wr_vld_d = 1'b1;
            phase_d  = PH_WR;
          end else begin
            arvalid_d = 1'b1;
            phase_d   = PH_AR;
          end
        end
      end
      PH_WR: begin
        if (m_awready && m_wready) begin
          done_o   = 1'b1;
          wr_vld_d = 1'b0;
          phase_d  = PH_IDLE;
        end else if (tmo_last) begin
          timeout_o = 1'b1;
          wr_vld_d  = 1'b0;
          phase_d   = PH_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PH_AR: begin
        if (m_arready) begin
          ar_acc_o  = 1'b1;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = '0;
          phase_d   = PH_R;
        end else if (tmo_last) begin
          timeout_o = 1'b1;
          arvalid_d = 1'b0;
          phase_d   = PH_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PH_R: begin
        if (m_rvalid) begin
          done_o   = 1'b1;
          rready_d = 1'b0;
          phase_d  = PH_IDLE;
        end else if (tmo_last) begin
          timeout_o = 1'b1;
          rready_d  = 1'b0;
          phase_d   = PH_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign m_awvalid = wr_vld_q;
  assign m_wvalid  = wr_vld_q;
  assign m_awaddr  = pADDR_WIDTH'(SERDES_CTRL_OFFSET);
  assign m_wdata   = wdata_q;
  assign m_wstrb   = '1;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = pADDR_WIDTH'(SERDES_CTRL_OFFSET);
  assign m_rready  = rready_q;
  assign rdata_o   = m_rdata;

endmodule

// File: rtl/io_serdes_link_ctrl.sv
// IO_SERDES link bring-up: enable RX, wait for it to settle, enable TX, then read
// back and retry the TX write on mismatch. Holds the sequencing FSM and status.
module io_serdes_link_ctrl
  import io_serdes_pkg::*;
#(
  parameter int pADDR_WIDTH = 10,
  parameter int pDATA_WIDTH = 32,
  parameter int pRX_SETTLE  = 16,
  parameter int pTIMEOUT    = 64,
  parameter int pMAX_RETRY  = 3
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     m_awvalid,
  output logic [pADDR_WIDTH-1:0]   m_awaddr,
  input  logic                     m_awready,
  output logic                     m_wvalid,
  output logic [pDATA_WIDTH-1:0]   m_wdata,
  output logic [pDATA_WIDTH/8-1:0] m_wstrb,
  input  logic                     m_wready,
  output logic                     m_arvalid,
  output logic [pADDR_WIDTH-1:0]   m_araddr,
  input  logic                     m_arready,
  input  logic                     m_rvalid,
  input  logic [pDATA_WIDTH-1:0]   m_rdata,
  output logic                     m_rready,
  output logic                     cc_ls_enable,
  output logic                     busy,
  output logic                     link_up,
  output logic                     link_err,
  output logic [1:0]               err_code,
  output logic [3:0]               retry_cnt
);

  localparam int SW = (pRX_SETTLE > 1) ? $clog2(pRX_SETTLE) : 1;
  localparam logic [pDATA_WIDTH-1:0] RX_WORD = pDATA_WIDTH'(1 << RXEN_BIT);
  localparam logic [pDATA_WIDTH-1:0] TX_WORD = pDATA_WIDTH'((1 << RXEN_BIT) | (1 << TXEN_BIT));

  link_state_e             state_q, state_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [3:0]              retry_q, retry_d;
  logic [1:0]              err_q, err_d;
  logic                    req_q, req_d;

  logic                    lm_wr;
  logic [pDATA_WIDTH-1:0]  lm_wdata;
  logic                    lm_done;
  logic                    lm_ar_acc;
  logic                    lm_timeout;
  logic [pDATA_WIDTH-1:0]  lm_rdata;
  logic                    rb_ok;
  logic                    rdata_unused;

  assign lm_wr        = (state_q != ST_RD_REQ);
  assign lm_wdata     = (state_q == ST_WR_RX) ? RX_WORD : TX_WORD;
  assign rb_ok        = lm_rdata[RXEN_BIT] && lm_rdata[TXEN_BIT];
  assign rdata_unused = ^lm_rdata;

  io_serdes_lite_master #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH),
    .pTIMEOUT    (pTIMEOUT)
  ) u_lite (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .req_i       (req_q),
    .wr_i        (lm_wr),
    .wdata_i     (lm_wdata),
    .done_o      (lm_done),
    .ar_acc_o    (lm_ar_acc),
    .timeout_o   (lm_timeout),
    .rdata_o     (lm_rdata),
    .m_awvalid   (m_awvalid),
    .m_awaddr    (m_awaddr),
    .m_awready   (m_awready),
    .m_wvalid    (m_wvalid),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_wready    (m_wready),
    .m_arvalid   (m_arvalid),
    .m_araddr    (m_araddr),
    .m_arready   (m_arready),
    .m_rvalid    (m_rvalid),
    .m_rdata     (m_rdata),
    .m_rready    (m_rready)
  );

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      retry_q  <= '0;
      err_q    <= ERR_NONE;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
      req_q    <= req_d;
    end
  end

  // req_d pulses on entry to each transaction state; abort is only honoured
  // where no handshake is in flight.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    retry_d  = retry_q;
    err_d    = err_q;
    req_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (abort) begin
          retry_d = '0;
          err_d   = ERR_NONE;
        end else if (start) begin
          retry_d = '0;
          err_d   = ERR_NONE;
          state_d = ST_WR_RX;
          req_d   = 1'b1;
        end
      end
      ST_WR_RX: begin
        if (lm_done) begin
          if (abort) begin
            state_d = ST_IDLE;
            retry_d = '0;
            err_d   = ERR_NONE;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = '0;
          end
        end else if (lm_timeout) begin
          state_d = ST_ERR;
          err_d   = ERR_WR_TMO;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          retry_d = '0;
          err_d   = ERR_NONE;
        end else if (settle_q == SW'(pRX_SETTLE - 1)) begin
          state_d = ST_WR_TX;
          req_d   = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_WR_TX: begin
        if (lm_done) begin
          if (abort) begin
            state_d = ST_IDLE;
            retry_d = '0;
            err_d   = ERR_NONE;
          end else begin
            state_d = ST_RD_REQ;
            req_d   = 1'b1;
          end
        end else if (lm_timeout) begin
          state_d = ST_ERR;
          err_d   = ERR_WR_TMO;
        end
      end
      ST_RD_REQ: begin
        if (lm_ar_acc) begin
          state_d = ST_RD_DAT;
        end else if (lm_timeout) begin
          state_d = ST_ERR;
          err_d   = ERR_RD_TMO;
        end
      end
      ST_RD_DAT: begin
        if (lm_done) begin
          if (abort) begin
            state_d = ST_IDLE;
            retry_d = '0;
            err_d   = ERR_NONE;
          end else if (rb_ok) begin
            state_d = ST_UP;
          end else if (retry_q < 4'(pMAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_WR_TX;
            req_d   = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_MISMATCH;
          end
        end else if (lm_timeout) begin
          state_d = ST_ERR;
          err_d   = ERR_RD_TMO;
        end
      end
      ST_UP: begin
        if (abort) begin
          state_d = ST_IDLE;
          retry_d = '0;
          err_d   = ERR_NONE;
        end
      end
      ST_ERR: begin
        if (abort) begin
          state_d = ST_IDLE;
          retry_d = '0;
          err_d   = ERR_NONE;
        end else if (start) begin
          retry_d = '0;
          err_d   = ERR_NONE;
          state_d = ST_WR_RX;
          req_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cc_ls_enable = m_awvalid | m_wvalid | m_arvalid | m_rready;
  assign busy         = !(state_q inside {ST_IDLE, ST_UP, ST_ERR});
  assign link_up      = (state_q == ST_UP);
  assign link_err     = (state_q == ST_ERR);
  assign err_code     = err_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_io_serdes_link_ctrl.sv
// Bench for io_serdes_link_ctrl: serdes register model, write scoreboard,
// scenario table and hand-written sequences for abort, reset and timeout timing.
module tb_io_serdes_link_ctrl;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int SET = 16;
  localparam int TMO = 64;
  localparam int MXR = 3;

  logic            axi_clk = 1'b0;
  logic            axi_reset_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            m_awvalid, m_awready, m_wvalid, m_wready;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic            cc_ls_enable, busy, link_up, link_err;
  logic [1:0]      err_code;
  logic [3:0]      retry_cnt;

  always #5 axi_clk = ~axi_clk;

  io_serdes_link_ctrl #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pRX_SETTLE(SET), .pTIMEOUT(TMO), .pMAX_RETRY(MXR)
  ) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .start(start), .abort(abort),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
    .cc_ls_enable(cc_ls_enable), .busy(busy), .link_up(link_up), .link_err(link_err),
    .err_code(err_code), .retry_cnt(retry_cnt)
  );

  // Serdes model knobs
  logic wr_en = 1'b1;
  logic rv_en = 1'b1;
  int   wr_hold = 0;
  int   wcnt = 0;
  int   bad_reads = 0;
  int   rd_idx = 0;

  assign m_awready = wr_en && m_awvalid && (wcnt >= wr_hold);
  assign m_wready  = m_awready;
  assign m_arready = m_arvalid;
  assign m_rvalid  = rv_en && m_rready;
  assign m_rdata   = (rd_idx < bad_reads) ? 32'h1 : 32'h3;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int aw_hi_cnt = 0;
  int wr_hs_cnt = 0;
  int rx_cyc = 0;
  logic rx_pend = 1'b0;
  logic p_aw = 1'b0, p_ar = 1'b0, p_r = 1'b0;
  logic [DW-1:0] exp_wr[$];

  localparam logic [49:0] RST_VEC = {46'b0, 4'hF};

  typedef struct {
    string name;
    int    bad;
    logic  wen;
    logic  ren;
    int    n_wr;
    logic  up;
    logic  err;
    logic [1:0] code;
    logic [3:0] retry;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [49:0] out_vec();
    return {m_awvalid, m_wvalid, m_arvalid, m_rready, cc_ls_enable, busy, link_up, link_err,
            err_code, retry_cnt, m_wdata, m_wstrb};
  endfunction

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) exp_wr.push_back((i == 0) ? 32'h1 : 32'h3);
  endtask

  // One clock: observe at the falling edge, update the model just after the rising edge.
  task automatic cyc();
    logic whs, arhs, rhs, aw_s;
    logic [DW-1:0] e;
    @(negedge axi_clk);
    cyc_n++;
    whs  = m_awvalid && m_awready && m_wvalid && m_wready;
    arhs = m_arvalid && m_arready;
    rhs  = m_rvalid && m_rready;
    aw_s = m_awvalid;
    if (m_awvalid) aw_hi_cnt++;
    if (axi_reset_n) begin
      chk("cc_ls_enable", cc_ls_enable, m_awvalid | m_wvalid | m_arvalid | m_rready);
      if (p_aw) chk("aw_valid_held", m_awvalid || link_err, 1);
      if (p_ar) chk("ar_valid_held", m_arvalid || link_err, 1);
      if (p_r)  chk("rready_held", m_rready || link_err, 1);
      if (arhs) chk("ar_addr", m_araddr, 0);
      if (whs) begin
        wr_hs_cnt++;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {m_awaddr, m_wdata}, 42'h3ffffffffff);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_beat", {m_awaddr, m_wdata, m_wstrb}, {10'b0, e, 4'hF});
          if (m_wdata == 32'h1) begin
            rx_cyc  = cyc_n;
            rx_pend = 1'b1;
          end else if (rx_pend) begin
            chk("rx_tx_spacing_ok", (cyc_n - rx_cyc) >= SET, 1);
            rx_pend = 1'b0;
          end
        end
      end
      p_aw = m_awvalid && !whs;
      p_ar = m_arvalid && !arhs;
      p_r  = m_rready && !rhs;
    end else begin
      p_aw = 1'b0; p_ar = 1'b0; p_r = 1'b0;
    end
    @(posedge axi_clk);
    #1;
    if (aw_s && !whs) wcnt++;
    else wcnt = 0;
    if (rhs) rd_idx++;
  endtask

  task automatic do_reset();
    axi_reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    wr_hold = 0; wcnt = 0; rd_idx = 0; rx_pend = 1'b0;
    exp_wr.delete();
    #1;
    chk("reset_outputs", out_vec(), RST_VEC);
    cyc();
    cyc();
    axi_reset_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_link(input int budget, input string nm);
    int n;
    n = 0;
    while (!(link_up || link_err) && n < budget) begin
      cyc();
      n++;
    end
    chk({nm, "_finished_in_budget"}, (link_up || link_err), 1);
  endtask

  initial begin
    vecs[0] = '{"nominal",    0, 1'b1, 1'b1, 2, 1'b1, 1'b0, 2'd0, 4'd0};
    vecs[1] = '{"bad2",       2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 2'd0, 4'd2};
    vecs[2] = '{"bad3",       3, 1'b1, 1'b1, 5, 1'b1, 1'b0, 2'd0, 4'd3};
    vecs[3] = '{"bad4",       4, 1'b1, 1'b1, 5, 1'b0, 1'b1, 2'd3, 4'd3};
    vecs[4] = '{"wr_timeout", 0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 2'd1, 4'd0};
    vecs[5] = '{"rd_timeout", 0, 1'b1, 1'b0, 2, 1'b0, 1'b1, 2'd2, 4'd0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      bad_reads = vecs[v].bad;
      wr_en     = vecs[v].wen;
      rv_en     = vecs[v].ren;
      push_writes(vecs[v].n_wr);
      pulse_start();
      wait_link(800, vecs[v].name);
      cyc();
      chk({vecs[v].name, "_link_up"},   link_up,   vecs[v].up);
      chk({vecs[v].name, "_link_err"},  link_err,  vecs[v].err);
      chk({vecs[v].name, "_err_code"},  err_code,  vecs[v].code);
      chk({vecs[v].name, "_retry_cnt"}, retry_cnt, vecs[v].retry);
      chk({vecs[v].name, "_busy"},      busy,      0);
      chk({vecs[v].name, "_writes_left"}, exp_wr.size(), 0);
    end

    // Write timeout timing, then start+abort together in ERR
    do_reset();
    wr_en = 1'b0; bad_reads = 0; rv_en = 1'b1;
    aw_hi_cnt = 0;
    pulse_start();
    wait_link(200, "wr_tmo_timing");
    chk("wr_tmo_valid_cycles", aw_hi_cnt, TMO);
    chk("wr_tmo_valids_low", {m_awvalid, m_wvalid, cc_ls_enable}, 0);
    chk("wr_tmo_code", err_code, 1);
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    cyc();
    chk("start_abort_err_to_idle", {link_err, busy, err_code, retry_cnt}, 0);
    repeat (10) cyc();
    chk("start_abort_stays_idle", {busy, m_awvalid}, 0);

    // Read timeout, then restart from ERR with a good model
    do_reset();
    wr_en = 1'b1; rv_en = 1'b0; bad_reads = 0;
    push_writes(2);
    pulse_start();
    wait_link(400, "rd_tmo");
    chk("rd_tmo_code", err_code, 2);
    rv_en = 1'b1; rd_idx = 0;
    push_writes(2);
    pulse_start();
    chk("restart_clears_err", {link_err, err_code, busy}, 3'b001);
    wait_link(400, "restart");
    chk("restart_link_up", {link_up, err_code, retry_cnt}, 7'b1000000);

    // start while UP is ignored, then abort leaves UP
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (20) cyc();
    chk("up_ignores_start", {link_up, busy}, 2'b10);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cyc();
    chk("abort_from_up", {link_up, busy, err_code, retry_cnt}, 0);

    // Abort while the RX write is held off for 10 cycles
    do_reset();
    wr_en = 1'b1; rv_en = 1'b1; wr_hold = 10; bad_reads = 0;
    aw_hi_cnt = 0; wr_hs_cnt = 0;
    push_writes(1);
    pulse_start();
    for (int i = 0; i < 20 && !m_awvalid; i++) cyc();
    chk("abort_seq_valid_seen", m_awvalid, 1);
    abort = 1'b1;
    for (int i = 0; i < 60 && busy; i++) cyc();
    chk("abort_seq_idle", {busy, link_up, link_err, err_code, retry_cnt}, 0);
    chk("abort_seq_valid_cycles", aw_hi_cnt, 11);
    repeat (20) cyc();
    abort = 1'b0;
    repeat (40) cyc();
    chk("abort_seq_one_write", wr_hs_cnt, 1);
    chk("abort_seq_no_activity", {busy, m_awvalid, m_arvalid}, 0);

    // Reset asserted while in SETTLE
    do_reset();
    wr_en = 1'b1; rv_en = 1'b1; bad_reads = 0; wr_hs_cnt = 0;
    push_writes(1);
    pulse_start();
    for (int i = 0; i < 20 && wr_hs_cnt == 0; i++) cyc();
    repeat (3) cyc();
    chk("settle_busy_no_valid", {busy, cc_ls_enable}, 2'b10);
    #2;
    axi_reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), RST_VEC);
    wcnt = 0; rd_idx = 0; rx_pend = 1'b0;
    cyc();
    cyc();
    axi_reset_n = 1'b1;
    exp_wr.delete();
    push_writes(2);
    pulse_start();
    wait_link(400, "after_reset");
    chk("after_reset_up", {link_up, link_err, err_code, retry_cnt}, 8'b10000000);
    chk("after_reset_writes_left", exp_wr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
